// File: rtl/tea_core_iter.sv
// tea_core_iter: iterative TEA block cipher engine, one Feistel round per clock.
//
// A request is accepted in IDLE (in_valid & in_ready), executes ROUNDS rounds in
// RUN, and is presented in DONE until the consumer takes it (out_valid & out_ready).
// Both encryption and decryption are supported; the direction is latched at accept.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request presented
//   in_ready   out  engine can accept a request (IDLE)
//   mode       in   0 = encrypt, 1 = decrypt (sampled at accept)
//   key        in   {k3,k2,k1,k0}, k0 in the LSBs (sampled at accept)
//   v_in       in   {v1,v0}, v0 in the LSBs (sampled at accept)
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes the result
//   v_out      out  {v1,v0} result, held until the next completion
//   out_mode   out  mode of the request that produced v_out
//   busy       out  high in RUN or DONE
module tea_core_iter #(
  parameter int          W      = 32,
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  input  logic [4*W-1:0] key,
  input  logic [2*W-1:0] v_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] v_out,
  output logic           out_mode,
  output logic           busy
);

  localparam logic [W-1:0] DELTA_W  = W'(DELTA);
  // Starting sum for decryption: the value encryption ends with, mod 2^W.
  localparam logic [W-1:0] SUM_DEC  = W'(DELTA_W * W'(ROUNDS));
  localparam logic [7:0]   LAST_RND = 8'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     v0_q, v0_d;
  logic [W-1:0]     v1_q, v1_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [4*W-1:0]   key_q, key_d;
  logic             mode_q, mode_d;
  logic [2*W-1:0]   v_out_q, v_out_d;
  logic             out_mode_q, out_mode_d;

  logic [W-1:0]     k0_s, k1_s, k2_s, k3_s;
  logic [W-1:0]     enc_sum_s, enc_v0_s, enc_v1_s;
  logic [W-1:0]     dec_sum_s, dec_v0_s, dec_v1_s;

  // TEA mixing function; every add wraps at W bits, shifts are logical.
  function automatic logic [W-1:0] tea_f(
    input logic [W-1:0] x,
    input logic [W-1:0] ka,
    input logic [W-1:0] kb,
    input logic [W-1:0] s
  );
    return ((x << 3'd4) + ka) ^ (x + s) ^ ((x >> 3'd5) + kb);
  endfunction

  assign k0_s = key_q[W-1:0];
  assign k1_s = key_q[2*W-1:W];
  assign k2_s = key_q[3*W-1:2*W];
  assign k3_s = key_q[4*W-1:3*W];

  // One encrypt round and one decrypt round from the current working state.
  always_comb begin
    // Encrypt advances sum first and uses the advanced value in both halves.
    enc_sum_s = sum_q + DELTA_W;
    enc_v0_s  = v0_q + tea_f(v1_q, k0_s, k1_s, enc_sum_s);
    enc_v1_s  = v1_q + tea_f(enc_v0_s, k2_s, k3_s, enc_sum_s);
    // Decrypt undoes the halves in reverse order with the current sum.
    dec_v1_s  = v1_q - tea_f(v0_q, k2_s, k3_s, sum_q);
    dec_v0_s  = v0_q - tea_f(dec_v1_s, k0_s, k1_s, sum_q);
    dec_sum_s = sum_q - DELTA_W;
  end

  // Next-state and datapath register updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d    = state_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    mode_d     = mode_q;
    v_out_d    = v_out_q;
    out_mode_d = out_mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          key_d   = key;
          mode_d  = mode;
          v0_d    = v_in[W-1:0];
          v1_d    = v_in[2*W-1:W];
          sum_d   = mode ? SUM_DEC : {W{1'b0}};
          cnt_d   = 8'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (mode_q) begin
          v0_d  = dec_v0_s;
          v1_d  = dec_v1_s;
          sum_d = dec_sum_s;
        end else begin
          v0_d  = enc_v0_s;
          v1_d  = enc_v1_s;
          sum_d = enc_sum_s;
        end
        if (cnt_q == LAST_RND) begin
          // Capture the final round straight into the output register.
          v_out_d    = mode_q ? {dec_v1_s, dec_v0_s} : {enc_v1_s, enc_v0_s};
          out_mode_d = mode_q;
          state_d    = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      v0_q       <= {W{1'b0}};
      v1_q       <= {W{1'b0}};
      sum_q      <= {W{1'b0}};
      cnt_q      <= 8'd0;
      key_q      <= {(4*W){1'b0}};
      mode_q     <= 1'b0;
      v_out_q    <= {(2*W){1'b0}};
      out_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      v_out_q    <= v_out_d;
      out_mode_q <= out_mode_d;
    end
  end

  // Handshake flags are direct decodes of the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign v_out     = v_out_q;
  assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_tea_core_iter.sv
// Self-checking bench for tea_core_iter: a 32-bit instance and the legacy 8-bit
// instance, both compared every cycle against a transaction-level TEA model.
module tb_tea_core_iter;

  localparam int R = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0 drives the 32-bit instance, index 1 the 8-bit instance.
  logic         iv     [2];
  logic         mode_i [2];
  logic         ordy   [2];
  logic [127:0] key_i  [2];
  logic [63:0]  vin_i  [2];

  logic         ir32, ov32, om32, bz32;
  logic [63:0]  vo32;
  logic         ir8, ov8, om8, bz8;
  logic [15:0]  vo8;

  int n_cmp = 0;
  int n_err = 0;

  tea_core_iter #(.W(32), .ROUNDS(R), .DELTA(32'h9E3779B9)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir32), .mode(mode_i[0]),
    .key(key_i[0]), .v_in(vin_i[0]), .out_valid(ov32), .out_ready(ordy[0]),
    .v_out(vo32), .out_mode(om32), .busy(bz32));

  tea_core_iter #(.W(8), .ROUNDS(R), .DELTA(32'h000000B7)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir8), .mode(mode_i[1]),
    .key(key_i[1][31:0]), .v_in(vin_i[1][15:0]), .out_valid(ov8), .out_ready(ordy[1]),
    .v_out(vo8), .out_mode(om8), .busy(bz8));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference TEA (C-style, masked to w bits) ----------------
  function automatic bit [31:0] f_rnd(bit [31:0] x, bit [31:0] ka, bit [31:0] kb,
                                      bit [31:0] s, bit [31:0] m);
    return (((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb)) & m;
  endfunction

  function automatic bit [63:0] tea_model(bit [63:0] v, bit [127:0] k, bit dec,
                                          int w, bit [31:0] delta);
    bit [31:0] m, v0, v1, sum, dl;
    bit [31:0] kk [4];
    m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    v0 = v[31:0] & m;
    v1 = 32'(v >> w) & m;
    for (int i = 0; i < 4; i++) kk[i] = 32'(k >> (i * w)) & m;
    dl  = delta & m;
    sum = dec ? ((dl * 32'(R)) & m) : 32'd0;
    for (int r = 0; r < R; r++) begin
      if (!dec) begin
        sum = (sum + dl) & m;
        v0  = (v0 + f_rnd(v1, kk[0], kk[1], sum, m)) & m;
        v1  = (v1 + f_rnd(v0, kk[2], kk[3], sum, m)) & m;
      end else begin
        v1  = (v1 - f_rnd(v0, kk[2], kk[3], sum, m)) & m;
        v0  = (v0 - f_rnd(v1, kk[0], kk[1], sum, m)) & m;
        sum = (sum - dl) & m;
      end
    end
    return (64'(v1) << w) | 64'(v0);
  endfunction

  function automatic int w_of(int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic bit [31:0] delta_of(int d);
    return (d == 0) ? 32'h9E3779B9 : 32'h000000B7;
  endfunction

  // ---------------- transaction-level model of each engine ----------------
  bit        m_busy [2];
  bit        m_done [2];
  int        m_cnt  [2];
  bit [63:0] m_res  [2];
  bit        m_pmd  [2];
  bit [63:0] m_vout [2];
  bit        m_mode [2];
  int        cyc = 0;
  int        acc_q0[$];
  int        n_hs0 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] <= 1'b0; m_done[d] <= 1'b0; m_cnt[d] <= 0;
        m_vout[d] <= 64'd0; m_mode[d] <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      if (ov32 && ordy[0]) n_hs0 <= n_hs0 + 1;
      for (int d = 0; d < 2; d++) begin
        if (!m_busy[d]) begin
          if (iv[d]) begin
            m_busy[d] <= 1'b1;
            m_cnt[d]  <= R;
            m_res[d]  <= tea_model(vin_i[d], key_i[d], mode_i[d], w_of(d), delta_of(d));
            m_pmd[d]  <= mode_i[d];
            if (d == 0) acc_q0.push_back(cyc);
          end
        end else if (!m_done[d]) begin
          m_cnt[d] <= m_cnt[d] - 1;
          if (m_cnt[d] == 1) begin
            m_done[d] <= 1'b1;
            m_vout[d] <= m_res[d];
            m_mode[d] <= m_pmd[d];
          end
        end else if (ordy[d]) begin
          m_busy[d] <= 1'b0;
          m_done[d] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of both engines against the model.
  always @(negedge clk) begin
    chk("in_ready32",  ir32, !m_busy[0]);
    chk("busy32",      bz32, m_busy[0]);
    chk("out_valid32", ov32, m_done[0]);
    chk("v_out32",     vo32, m_vout[0]);
    chk("out_mode32",  om32, m_mode[0]);
    chk("in_ready8",   ir8,  !m_busy[1]);
    chk("busy8",       bz8,  m_busy[1]);
    chk("out_valid8",  ov8,  m_done[1]);
    chk("v_out8",      {48'd0, vo8}, m_vout[1]);
    chk("out_mode8",   om8,  m_mode[1]);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic ir_now(int d);
    return (d == 0) ? ir32 : ir8;
  endfunction

  function automatic logic ov_now(int d);
    return (d == 0) ? ov32 : ov8;
  endfunction

  // Presents a request at a negedge, holds it until accepted, then scrambles inputs.
  task automatic send(input int d, input bit md, input bit [127:0] k, input bit [63:0] v);
    int t;
    mode_i[d] = md; key_i[d] = k; vin_i[d] = v; iv[d] = 1'b1;
    t = 0;
    while (!ir_now(d) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", 64'(t < 200), 64'd1);
    @(negedge clk);
    iv[d]     = 1'b0;
    mode_i[d] = 1'($urandom);
    key_i[d]  = {$urandom, $urandom, $urandom, $urandom};
    vin_i[d]  = {$urandom, $urandom};
  endtask

  // Waits for out_valid (bounded), returns the result and cycles waited.
  task automatic recv(input int d, output bit [63:0] v, output bit md, output int t);
    t = 0;
    while (!ov_now(d) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("result_timeout", 64'(t < 400), 64'd1);
    v  = (d == 0) ? vo32 : {48'd0, vo8};
    md = (d == 0) ? om32 : om8;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [63:0]  c, p, held;
    bit [127:0] k;
    bit         md;
    int         t, h0, na;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; mode_i[d] = 1'b0; ordy[d] = 1'b1; key_i[d] = 128'd0; vin_i[d] = 64'd0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready", ir32, 1'b1);
    chk("rst_out_valid", ov32, 1'b0);
    chk("rst_busy", bz32, 1'b0);
    chk("rst_v_out", vo32, 64'd0);
    chk("rst_out_mode", om32, 1'b0);

    // Pin the model with the published zero vector
    chk("model_zero_enc", tea_model(64'd0, 128'd0, 1'b0, 32, 32'h9E3779B9),
        64'h94BAA940_41EA3A0A);
    chk("model_zero_dec", tea_model(64'h94BAA940_41EA3A0A, 128'd0, 1'b1, 32, 32'h9E3779B9),
        64'd0);

    // Zero vector and latency
    send(0, 1'b0, 128'd0, 64'd0);
    recv(0, c, md, t);
    chk("zero_latency", 64'(t), 64'(R));
    chk("zero_v_out", c, 64'h94BAA940_41EA3A0A);
    chk("zero_mode", 64'(md), 64'd0);

    // Round trip
    k = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    send(0, 1'b0, k, 64'h89ABCDEF_01234567);
    recv(0, c, md, t);
    send(0, 1'b1, k, c);
    recv(0, p, md, t);
    chk("rt_plain", p, 64'h89ABCDEF_01234567);
    chk("rt_mode", 64'(md), 64'd1);

    // Backpressure: hold DONE for 10 cycles with ignored in_valid pulses
    ordy[0] = 1'b0;
    send(0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
    t = 0;
    while (!ov32 && t < 400) begin
      @(negedge clk);
      t++;
    end
    held = vo32;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", ov32, 1'b1);
      chk("bp_v_out", vo32, held);
      chk("bp_in_ready", ir32, 1'b0);
      iv[0]    = 1'(i % 2);
      vin_i[0] = {$urandom, $urandom};
      @(negedge clk);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", ir32, 1'b1);
    chk("bp_release_out_valid", ov32, 1'b0);
    chk("bp_v_out_retained", vo32, held);

    // Reset mid-run at round 15
    send(0, 1'b0, 128'd0, 64'd0);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", ir32, 1'b1);
    chk("arst_out_valid", ov32, 1'b0);
    chk("arst_busy", bz32, 1'b0);
    chk("arst_v_out", vo32, 64'd0);
    chk("arst_out_mode", om32, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (R + 4) begin
      @(negedge clk);
      chk("arst_no_pulse", ov32, 1'b0);
    end
    send(0, 1'b0, 128'd0, 64'd0);
    recv(0, c, md, t);
    chk("arst_fresh_zero", c, 64'h94BAA940_41EA3A0A);

    // Legacy 8-bit instance: 100 encrypt/decrypt pairs
    for (int i = 0; i < 100; i++) begin
      k = {96'd0, 32'($urandom)};
      p = {48'd0, 16'($urandom)};
      send(1, 1'b0, k, p);
      recv(1, c, md, t);
      send(1, 1'b1, k, c);
      recv(1, c, md, t);
      chk("legacy_roundtrip", c, p);
      if (i < 4) chk("legacy_mode", 64'(md), 64'd1);
    end

    // Back-to-back with in_valid held high
    acc_q0.delete();
    h0 = n_hs0;
    iv[0] = 1'b1;
    repeat (5 * (R + 2) + 3) begin
      mode_i[0] = 1'($urandom);
      key_i[0]  = {$urandom, $urandom, $urandom, $urandom};
      vin_i[0]  = {$urandom, $urandom};
      @(negedge clk);
    end
    t = 0;
    while (ir32 && t < 100) begin
      @(negedge clk);
      t++;
    end
    iv[0] = 1'b0;
    t = 0;
    while (bz32 && t < R + 10) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_drain", bz32, 1'b0);
    na = acc_q0.size();
    chk("b2b_enough_accepts", 64'(na >= 5), 64'd1);
    for (int i = 1; i < na; i++) chk("b2b_spacing", 64'(acc_q0[i] - acc_q0[i-1]), 64'(R + 2));
    chk("b2b_results", 64'(n_hs0 - h0), 64'(na));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
